// File: rtl/alu_mdu_if.sv
// Request/result bundle between the EX-stage issuer and the multiply/divide unit.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/alu_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; result WIDTH+1 edges after the start edge.
// No backpressure: start is ignored while busy, so the issuer stalls on busy.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   mag_b, a_raw, hi_q, lo_q;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [1:0]         op_q;
  logic               neg_a, neg_b, done_q, dz_q;
  logic               accept, wr_hi, wr_lo, sgn_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op[2])             accept = 1'b1;
          else if (bus.op == 3'd4)    wr_hi  = 1'b1;
          else if (bus.op == 3'd5)    wr_lo  = 1'b1;
        end
        if (accept) state_nxt = RUN;
      end
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Signed ops iterate on magnitudes; the signs are re-applied in FIX.
  always_comb begin
    sgn_in   = ~bus.op[0];
    mag_a_in = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b_in = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // Both algorithms start from {0, |a|}: multiply shifts the multiplier out of
  // the low half, divide shifts the dividend out of it and the quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, mag_b};
    if (op_q[1])
      acc_step = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod_fix = (!op_q[0] && (neg_a ^ neg_b)) ? -acc : acc;
    quo_fix  = (!op_q[0] && (neg_a ^ neg_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = (!op_q[0] && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!op_q[1]) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (mag_b == '0) begin
      hi_res = a_raw;
      lo_res = '1;
    end else begin
      hi_res = rem_fix;
      lo_res = quo_fix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mag_b  <= '0;
      a_raw  <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      if (accept) begin
        acc   <= {{WIDTH{1'b0}}, mag_a_in};
        mag_b <= mag_b_in;
        a_raw <= bus.a;
        op_q  <= bus.op[1:0];
        neg_a <= sgn_in & bus.a[WIDTH-1];
        neg_b <= sgn_in & bus.b[WIDTH-1];
        dz_q  <= 1'b0;
        cnt   <= '0;
      end
      if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
      end
      if (wr_hi) hi_q <= bus.a;
      if (wr_lo) lo_q <= bus.a;
      if (state == FIX) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
        dz_q <= op_q[1] && (mag_b == '0);
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dz_q;
endmodule
